// File: rtl/id_ex_fwd_reg.sv
// ID/EX pipeline register with load-use hazard detection, flush handling,
// MEM/WB forwarding select generation and a saturating bubble counter.
module id_ex_fwd_reg #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REGW-1:0]  id_rs1,
  input  logic [REGW-1:0]  id_rs2,
  input  logic [REGW-1:0]  id_rd,
  input  logic [WIDTH-1:0] id_rd1,
  input  logic [WIDTH-1:0] id_rd2,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             flush_i,
  input  logic [REGW-1:0]  mem_rd,
  input  logic [REGW-1:0]  wb_rd,
  input  logic             mem_regwrite,
  input  logic             wb_regwrite,
  output logic             ex_valid,
  output logic             ex_regwrite,
  output logic             ex_memread,
  output logic [REGW-1:0]  ex_rs1,
  output logic [REGW-1:0]  ex_rs2,
  output logic [REGW-1:0]  ex_rd,
  output logic [WIDTH-1:0] ex_rd1,
  output logic [WIDTH-1:0] ex_rd2,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             stall_o,
  output logic [15:0]      bubble_cnt
);

  logic             ex_valid_q, ex_valid_d;
  logic             ex_regwrite_q, ex_regwrite_d;
  logic             ex_memread_q, ex_memread_d;
  logic [REGW-1:0]  ex_rs1_q, ex_rs1_d;
  logic [REGW-1:0]  ex_rs2_q, ex_rs2_d;
  logic [REGW-1:0]  ex_rd_q, ex_rd_d;
  logic [WIDTH-1:0] ex_rd1_q, ex_rd1_d;
  logic [WIDTH-1:0] ex_rd2_q, ex_rd2_d;
  logic [15:0]      bubble_cnt_q, bubble_cnt_d;
  logic             stall;
  logic             bubble;
  logic             count_bubble;

  // MEM wins over WB so the youngest producer is forwarded; x0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic            vld,
                                         input logic [REGW-1:0] rs,
                                         input logic            mem_we,
                                         input logic [REGW-1:0] mem_a,
                                         input logic            wb_we,
                                         input logic [REGW-1:0] wb_a);
    logic [1:0] sel;
    sel = 2'b00;
    if (vld && rs != '0) begin
      if (mem_we && mem_a == rs)    sel = 2'b10;
      else if (wb_we && wb_a == rs) sel = 2'b01;
    end
    return sel;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    stall = ex_valid_q && ex_memread_q && (ex_rd_q != '0) && id_valid &&
            ((ex_rd_q == id_rs1) || (ex_rd_q == id_rs2)) && !flush_i;
    bubble       = flush_i || stall || !id_valid;
    count_bubble = (flush_i || stall) && (id_valid || ex_valid_q);

    ex_valid_d    = id_valid;
    ex_regwrite_d = id_regwrite;
    ex_memread_d  = id_memread;
    ex_rs1_d      = id_rs1;
    ex_rs2_d      = id_rs2;
    ex_rd_d       = id_rd;
    ex_rd1_d      = id_rd1;
    ex_rd2_d      = id_rd2;
    bubble_cnt_d  = bubble_cnt_q;

    // A bubble clears control and rd but keeps the operand/address fields.
    if (bubble) begin
      ex_valid_d    = 1'b0;
      ex_regwrite_d = 1'b0;
      ex_memread_d  = 1'b0;
      ex_rd_d       = '0;
      ex_rs1_d      = ex_rs1_q;
      ex_rs2_d      = ex_rs2_q;
      ex_rd1_d      = ex_rd1_q;
      ex_rd2_d      = ex_rd2_q;
    end
    if (count_bubble) bubble_cnt_d = sat_inc(bubble_cnt_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q    <= 1'b0;
      ex_regwrite_q <= 1'b0;
      ex_memread_q  <= 1'b0;
      ex_rs1_q      <= '0;
      ex_rs2_q      <= '0;
      ex_rd_q       <= '0;
      ex_rd1_q      <= '0;
      ex_rd2_q      <= '0;
      bubble_cnt_q  <= '0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_regwrite_q <= ex_regwrite_d;
      ex_memread_q  <= ex_memread_d;
      ex_rs1_q      <= ex_rs1_d;
      ex_rs2_q      <= ex_rs2_d;
      ex_rd_q       <= ex_rd_d;
      ex_rd1_q      <= ex_rd1_d;
      ex_rd2_q      <= ex_rd2_d;
      bubble_cnt_q  <= bubble_cnt_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_regwrite = ex_regwrite_q;
  assign ex_memread  = ex_memread_q;
  assign ex_rs1      = ex_rs1_q;
  assign ex_rs2      = ex_rs2_q;
  assign ex_rd       = ex_rd_q;
  assign ex_rd1      = ex_rd1_q;
  assign ex_rd2      = ex_rd2_q;
  assign bubble_cnt  = bubble_cnt_q;
  assign stall_o     = stall;
  assign fwd_a_sel   = fwd_sel(ex_valid_q, ex_rs1_q, mem_regwrite, mem_rd, wb_regwrite, wb_rd);
  assign fwd_b_sel   = fwd_sel(ex_valid_q, ex_rs2_q, mem_regwrite, mem_rd, wb_regwrite, wb_rd);

endmodule
